// File: rtl/hiscore_uploader.sv
// rtl/hiscore_uploader.sv - HPS upload read server fetching bytes from on-core memory via req/ack.
// Optional feature macro: UPLOAD_PAUSE_EN (halts the game CPU for PAUSE_DLY cycles before serving reads).
module hiscore_uploader #(
  parameter int          ADDR_W    = 10,
  parameter logic [24:0] BASE      = 25'h0,
  parameter int          SIZE      = 1024,
  parameter int          TIMEOUT   = 255,
  parameter int          PAUSE_DLY = 16
) (
  input  logic              clk_49m,
  input  logic              n_reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              pause_cpu,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {IDLE, PAUSE, READY, FETCH, DONE} state_t;

  localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

  state_t            r_state, w_nxt_state;
  logic              r_upload_d;
  logic [7:0]        r_din, w_nxt_din;
  logic              r_wait, w_nxt_wait;
  logic              r_req, w_nxt_req;
  logic [ADDR_W-1:0] r_addr, w_nxt_addr;
  logic              r_err, w_nxt_err;
  logic [7:0]        r_cnt, w_nxt_cnt;
  logic [ADDR_W:0]   r_bc, w_nxt_bc;
  logic [24:0]       w_offset;
  logic              w_in_range;

  // Addresses below BASE wrap to huge offsets and so fall out of range.
  assign w_offset   = ioctl_addr - BASE;
  assign w_in_range = (w_offset < 25'(SIZE));

  always_ff @(posedge clk_49m or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= IDLE;
      r_upload_d <= 1'b0;
      r_din      <= 8'h00;
      r_wait     <= 1'b0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_err      <= 1'b0;
      r_cnt      <= 8'h00;
      r_bc       <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_upload_d <= ioctl_upload;
      r_din      <= w_nxt_din;
      r_wait     <= w_nxt_wait;
      r_req      <= w_nxt_req;
      r_addr     <= w_nxt_addr;
      r_err      <= w_nxt_err;
      r_cnt      <= w_nxt_cnt;
      r_bc       <= w_nxt_bc;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_din   = r_din;
    w_nxt_wait  = r_wait;
    w_nxt_req   = r_req;
    w_nxt_addr  = r_addr;
    w_nxt_err   = r_err;
    w_nxt_cnt   = r_cnt;
    w_nxt_bc    = r_bc;
    if (!ioctl_upload) begin
      // Session ended: abandon any fetch, ioctl_din keeps its last byte.
      w_nxt_state = IDLE;
      w_nxt_req   = 1'b0;
      w_nxt_wait  = 1'b0;
    end else begin
      if (ioctl_rd && r_wait) w_nxt_err = 1'b1;
      case (r_state)
        IDLE: begin
          if (!r_upload_d) begin
            w_nxt_bc  = '0;
            w_nxt_err = 1'b0;
            w_nxt_cnt = 8'h00;
`ifdef UPLOAD_PAUSE_EN
            w_nxt_state = PAUSE;
            w_nxt_wait  = 1'b1;
`else
            w_nxt_state = READY;
`endif
          end
        end
`ifdef UPLOAD_PAUSE_EN
        PAUSE: begin
          if (r_cnt == 8'(PAUSE_DLY - 1)) begin
            w_nxt_wait  = 1'b0;
            w_nxt_state = READY;
          end else begin
            w_nxt_cnt = r_cnt + 8'd1;
          end
        end
`endif
        READY: begin
          if (ioctl_rd) begin
            w_nxt_wait = 1'b1;
            if (w_in_range) begin
              w_nxt_addr  = w_offset[ADDR_W-1:0];
              w_nxt_req   = 1'b1;
              w_nxt_cnt   = 8'h00;
              w_nxt_state = FETCH;
            end else begin
              w_nxt_din   = 8'h00;
              w_nxt_state = DONE;
            end
          end
        end
        FETCH: begin
          if (mem_ack) begin
            w_nxt_din   = mem_data;
            w_nxt_req   = 1'b0;
            w_nxt_state = DONE;
          end else if (r_cnt == TO_MAX) begin
            w_nxt_din   = 8'hFF;
            w_nxt_err   = 1'b1;
            w_nxt_req   = 1'b0;
            w_nxt_state = DONE;
          end else begin
            w_nxt_cnt = r_cnt + 8'd1;
          end
        end
        DONE: begin
          w_nxt_wait  = 1'b0;
          if (r_bc != '1) w_nxt_bc = r_bc + 1'b1;
          w_nxt_state = READY;
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

`ifdef UPLOAD_PAUSE_EN
  logic r_pause;
  always_ff @(posedge clk_49m or negedge n_reset) begin
    if (!n_reset)                r_pause <= 1'b0;
    else if (!ioctl_upload)      r_pause <= 1'b0;
    else if (r_state == IDLE)    r_pause <= 1'b1;
  end
  assign pause_cpu = r_pause;
`else
  localparam int unused_pause_dly = PAUSE_DLY;
  assign pause_cpu = 1'b0;
`endif

  assign ioctl_din  = r_din;
  assign ioctl_wait = r_wait;
  assign mem_req    = r_req;
  assign mem_addr   = r_addr;
  assign err        = r_err;
  assign byte_count = r_bc;

endmodule

// File: tb/tb_hiscore_uploader.sv
// tb/tb_hiscore_uploader.sv - directed self-checking bench for hiscore_uploader.
module tb_hiscore_uploader;

  logic        clk_49m = 1'b0;
  logic        n_reset;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        pause_cpu;
  logic        err;
  logic [10:0] byte_count;

  int total = 0;
  int bad   = 0;
  int ack_dly = 0;
  bit ack_en  = 1'b1;
  int req_cyc = 0;
  int req_seen = 0;

  hiscore_uploader dut (
    .clk_49m(clk_49m), .n_reset(n_reset), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .pause_cpu(pause_cpu),
    .err(err), .byte_count(byte_count)
  );

  always #5 clk_49m = ~clk_49m;

  function automatic logic [7:0] model(input logic [9:0] a);
    return (a[7:0] ^ 8'hA0) + {6'b0, a[9:8]};
  endfunction

  // Memory responder: acks ack_dly cycles into each request.
  always begin
    @(posedge clk_49m); #1;
    if (mem_req) req_seen++;
    if (ack_en) begin
      if (mem_req) begin
        if (req_cyc == ack_dly) begin
          mem_ack  = 1'b1;
          mem_data = model(mem_addr);
        end else begin
          mem_ack = 1'b0;
        end
        req_cyc++;
      end else begin
        mem_ack = 1'b0;
        req_cyc = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_49m); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 40 && ioctl_wait; n++) tick();
  endtask

  task automatic do_read(input logic [24:0] a);
    ioctl_rd = 1'b1; ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    wait_ready();
  endtask

  initial begin
    n_reset = 1'b0; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
    mem_ack = 1'b0; mem_data = 8'h00;
    tick(); tick();
    chk("rst_din",   32'(ioctl_din),  32'h00);
    chk("rst_wait",  32'(ioctl_wait), 32'h0);
    chk("rst_req",   32'(mem_req),    32'h0);
    chk("rst_addr",  32'(mem_addr),   32'h0);
    chk("rst_pause", 32'(pause_cpu),  32'h0);
    chk("rst_err",   32'(err),        32'h0);
    chk("rst_bc",    32'(byte_count), 32'h0);
    n_reset = 1'b1;
    tick();

    // Basic read with zero-wait ack
    ioctl_upload = 1'b1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'd5;
    tick();
    ioctl_rd = 1'b0;
    chk("basic_req_c1",  32'(mem_req),    32'h1);
    chk("basic_addr_c1", 32'(mem_addr),   32'd5);
    chk("basic_wait_c1", 32'(ioctl_wait), 32'h1);
    tick();
    chk("basic_din_c2",  32'(ioctl_din),  32'hA5);
    chk("basic_req_c2",  32'(mem_req),    32'h0);
    chk("basic_wait_c2", 32'(ioctl_wait), 32'h1);
    tick();
    chk("basic_wait_c3", 32'(ioctl_wait), 32'h0);
    chk("basic_bc",      32'(byte_count), 32'd1);

    // Streaming: fresh session, whole memory, ack delayed 3 cycles
    ioctl_upload = 1'b0; tick();
    ioctl_upload = 1'b1; tick();
    ack_dly = 3;
    for (int i = 0; i < 1024; i++) begin
      do_read(25'(i));
      chk($sformatf("stream_din_%0d", i), 32'(ioctl_din), 32'(model(10'(i))));
    end
    chk("stream_bc",  32'(byte_count), 32'd1024);
    chk("stream_err", 32'(err),        32'h0);

    // Range check: one past the end, and below BASE
    ack_dly = 0;
    req_seen = 0;
    ioctl_rd = 1'b1; ioctl_addr = 25'd1024;
    tick();
    ioctl_rd = 1'b0;
    chk("range_hi_din",  32'(ioctl_din),  32'h00);
    chk("range_hi_wait", 32'(ioctl_wait), 32'h1);
    tick();
    chk("range_hi_wait_c2", 32'(ioctl_wait), 32'h0);
    do_read(25'h1FF_FFFF);
    chk("range_lo_din", 32'(ioctl_din),  32'h00);
    chk("range_noreq",  32'(req_seen),   32'd0);
    chk("range_err",    32'(err),        32'h0);
    chk("range_bc",     32'(byte_count), 32'd1026);

    // Timeout: no ack ever
    ack_en = 1'b0; mem_ack = 1'b0;
    ioctl_rd = 1'b1; ioctl_addr = 25'd7;
    tick();
    ioctl_rd = 1'b0;
    chk("to_req_c1", 32'(mem_req), 32'h1);
    for (int i = 0; i < 255; i++) tick();
    chk("to_din_c256",  32'(ioctl_din), 32'h00);
    chk("to_req_c256",  32'(mem_req),   32'h1);
    tick();
    chk("to_din_c257",  32'(ioctl_din), 32'hFF);
    chk("to_err",       32'(err),       32'h1);
    chk("to_req_c257",  32'(mem_req),   32'h0);
    tick();
    chk("to_wait_c258", 32'(ioctl_wait), 32'h0);
    ack_en = 1'b1;
    do_read(25'd9);
    chk("to_ready_din", 32'(ioctl_din),  32'hA9);
    chk("to_err_stick", 32'(err),        32'h1);
    chk("to_bc",        32'(byte_count), 32'd1028);

    // Abort mid-FETCH, then a late ack
    ack_en = 1'b0; mem_ack = 1'b0;
    ioctl_rd = 1'b1; ioctl_addr = 25'd10;
    tick();
    ioctl_rd = 1'b0;
    chk("abort_req_c1", 32'(mem_req), 32'h1);
    ioctl_upload = 1'b0;
    tick();
    chk("abort_req",  32'(mem_req),    32'h0);
    chk("abort_wait", 32'(ioctl_wait), 32'h0);
    mem_ack = 1'b1; mem_data = 8'h5A;
    tick(); tick();
    mem_ack = 1'b0;
    chk("abort_late_din", 32'(ioctl_din),  32'hA9);
    chk("abort_late_req", 32'(mem_req),    32'h0);
    chk("abort_bc_hold",  32'(byte_count), 32'd1028);
    ioctl_upload = 1'b1;
    tick();
    chk("abort_idle_err", 32'(err),        32'h0);
    chk("abort_idle_bc",  32'(byte_count), 32'd0);

    // Asynchronous reset mid-FETCH
    ioctl_rd = 1'b1; ioctl_addr = 25'd3;
    tick();
    ioctl_rd = 1'b0;
    chk("areset_req_pre", 32'(mem_req), 32'h1);
    #2 n_reset = 1'b0;
    #1;
    chk("areset_req",  32'(mem_req),    32'h0);
    chk("areset_wait", 32'(ioctl_wait), 32'h0);
    chk("areset_din",  32'(ioctl_din),  32'h00);
    chk("areset_addr", 32'(mem_addr),   32'h0);
    chk("areset_bc",   32'(byte_count), 32'h0);
    ioctl_upload = 1'b0;
    n_reset = 1'b1;
    ack_en = 1'b1;
    tick();

`ifdef UPLOAD_PAUSE_EN
    ioctl_upload = 1'b1;
    req_seen = 0;
    tick();
    chk("pause_cpu_c1",  32'(pause_cpu),  32'h1);
    chk("pause_wait_c1", 32'(ioctl_wait), 32'h1);
    ioctl_rd = 1'b1; ioctl_addr = 25'd2;
    tick();
    ioctl_rd = 1'b0;
    chk("pause_err", 32'(err), 32'h1);
    for (int i = 0; i < 14; i++) tick();
    chk("pause_wait_c16", 32'(ioctl_wait), 32'h1);
    tick();
    chk("pause_wait_c17", 32'(ioctl_wait), 32'h0);
    chk("pause_noreq",    32'(req_seen),   32'd0);
    do_read(25'd2);
    chk("pause_din",  32'(ioctl_din), 32'hA2);
    chk("pause_hold", 32'(pause_cpu), 32'h1);
    ioctl_upload = 1'b0;
    tick();
    chk("pause_drop", 32'(pause_cpu), 32'h0);
`else
    ioctl_upload = 1'b1;
    tick();
    chk("nopause_cpu",  32'(pause_cpu),  32'h0);
    chk("nopause_wait", 32'(ioctl_wait), 32'h0);
    do_read(25'd2);
    chk("nopause_din",  32'(ioctl_din), 32'hA2);
    ioctl_upload = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
